// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver frame sequencer.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] FLD_START  = 2'd0;
  localparam logic [1:0] FLD_DATA   = 2'd1;
  localparam logic [1:0] FLD_PARITY = 2'd2;
  localparam logic [1:0] FLD_STOP   = 2'd3;

  function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

  // Index 0 is the start bit; anything past data/parity is a stop bit.
  function automatic logic [1:0] field_of(input int idx, input int data_bits, input int parity_en);
    if (idx == 0) return FLD_START;
    if (idx <= data_bits) return FLD_DATA;
    if ((parity_en != 0) && (idx == data_bits + 1)) return FLD_PARITY;
    return FLD_STOP;
  endfunction

endpackage

// File: rtl/uart_rx_watchdog.sv
// Stalled-frame watchdog: counts enabled cycles, cleared by each baud strobe,
// pulses expire on the TIMEOUT_CYCLES-th consecutive cycle without one.
module uart_rx_watchdog #(
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = en && !clr && (cnt_q == LAST);
    cnt_d  = cnt_q + 1'b1;
    if (!en || clr || expire) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_frame_counter.sv
// Bit/frame sequencer for the UART receiver: counts baud strobes across one frame.
// Build option: define UART_RX_FRAME_TIMEOUT_EN to include the stalled-frame watchdog.
module uart_rx_frame_counter
  import uart_rx_pkg::*;
#(
  parameter int  DATA_BITS      = 8,
  parameter int  PARITY_EN      = 1,
  parameter int  STOP_BITS      = 1,
  parameter int  FCNT_W         = 16,
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int FRAME_BITS     = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS),
  localparam int CNT_W          = $clog2(FRAME_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              baud_pulse,
  output logic              busy,
  output logic              bit_strobe,
  output logic [CNT_W-1:0]  bit_idx,
  output logic [1:0]        bit_field,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                bit_strobe_q, bit_strobe_d;
  logic [CNT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [1:0]          bit_field_q, bit_field_d;
  logic                frame_done_q, frame_done_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                timeout_q, timeout_d;
  logic                wd_expire;

`ifdef UART_RX_FRAME_TIMEOUT_EN
  uart_rx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == RUN),
    .clr    (baud_pulse),
    .expire (wd_expire)
  );
`else
  // Watchdog compiled out: never expires, TIMEOUT_CYCLES has no effect.
  assign wd_expire = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    bit_strobe_d = 1'b0;
    bit_idx_d    = bit_idx_q;
    bit_field_d  = bit_field_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (wd_expire) begin
          state_d   = IDLE;
          count_d   = '0;
          timeout_d = 1'b1;
        end else if (baud_pulse) begin
          bit_strobe_d = 1'b1;
          bit_idx_d    = count_q;
          bit_field_d  = field_of(int'(count_q), DATA_BITS, PARITY_EN);
          if (count_q == LAST_IDX) begin
            // Last bit: strobe and frame_done land on the same DONE-entry edge.
            state_d      = DONE;
            count_d      = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        count_d = '0;
        state_d = start ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      busy_q       <= 1'b0;
      bit_strobe_q <= 1'b0;
      bit_idx_q    <= '0;
      bit_field_q  <= 2'd0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      bit_strobe_q <= bit_strobe_d;
      bit_idx_q    <= bit_idx_d;
      bit_field_q  <= bit_field_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign busy       = busy_q;
  assign bit_strobe = bit_strobe_q;
  assign bit_idx    = bit_idx_q;
  assign bit_field  = bit_field_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign timeout    = timeout_q;

endmodule
